// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter measurement sequencer.
// The optional autorange feature is controlled by FREQ_SEQ_AUTORANGE_EN (see freq_meter_seq).
package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    GATE,
    LATCH,
    HOLD
  } state_t;

  localparam int RANGE_W = 2;
  localparam logic [RANGE_W-1:0] MAX_RANGE = 2'd3;
  localparam int RANGE_SHIFT = 3;

  // Largest of three lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Gate window for a range: each range step shortens the gate by 8x, never below one cycle.
  function automatic int gate_len(input int gate_cycles, input logic [RANGE_W-1:0] rng);
    int g;
    g = gate_cycles >> (RANGE_SHIFT * int'(rng));
    return (g < 1) ? 1 : g;
  endfunction

endpackage

// File: rtl/freq_meter_seq_if.sv
// Control/strobe bundle between run control, the sequencer and the counter datapath.
interface freq_meter_seq_if;
  import freq_meter_pkg::*;

  logic               run;
  logic               single;
  logic               ovf;
  logic               w_enable;
  logic               clear;
  logic               save;
  logic               busy;
  logic               meas_done;
  logic [RANGE_W-1:0] range;

  modport master (
    output run, single, ovf,
    input  w_enable, clear, save, busy, meas_done, range
  );

  modport slave (
    input  run, single, ovf,
    output w_enable, clear, save, busy, meas_done, range
  );
endinterface

// File: rtl/freq_gate_timer.sv
// Loadable down-counter that times every sequencer phase; zero marks the last cycle of a phase.
module freq_gate_timer #(
  parameter int W = 8
) (
  input  logic         c_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] length,
  output logic         zero
);

  logic [W-1:0] count;

  // Load length-1 on phase entry, then count down and rest at zero.
  // NOTE: sequential state uses non-blocking assignments and an async reset so every
  // register updates from pre-edge values and clears without waiting for a clock.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= length - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/freq_meter_seq.sv
// Measurement sequencer: schedules clear -> gate -> latch -> hold strobes for the
// counter datapath, in one-shot or continuous mode.
// Optional macro FREQ_SEQ_AUTORANGE_EN: on gate overflow, retry with an 8x shorter gate.
module freq_meter_seq
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CLR_CYCLES  = 2,
  parameter int HOLD_CYCLES = 10
) (
  input  logic             c_clk,
  input  logic             reset,
  freq_meter_seq_if.slave  bus
);

  localparam int TIMER_W = $clog2(max3(GATE_CYCLES, CLR_CYCLES, HOLD_CYCLES) + 1);

  state_t               state;
  state_t               state_next;
  logic                 load;
  logic [TIMER_W-1:0]   load_len;
  logic                 zero;
  logic [RANGE_W-1:0]   range_q;
  logic                 retry;

  freq_gate_timer #(.W(TIMER_W)) u_timer (
    .c_clk  (c_clk),
    .reset  (reset),
    .load   (load),
    .length (load_len),
    .zero   (zero)
  );

`ifdef FREQ_SEQ_AUTORANGE_EN
  logic ovf_flag;

  // Sticky overflow seen during the gate; cleared on every entry to CLR.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if (state_next == CLR) begin
      ovf_flag <= 1'b0;
    end else if (state == GATE && bus.ovf) begin
      ovf_flag <= 1'b1;
    end
  end

  // Range restarts at 0 for each new run and steps up on an overflow retry.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      range_q <= '0;
    end else if (state == IDLE && state_next == CLR) begin
      range_q <= '0;
    end else if (state == LATCH && retry) begin
      range_q <= range_q + RANGE_W'(1);
    end
  end

  assign retry = ovf_flag && (range_q != MAX_RANGE);
`else
  assign retry   = 1'b0;
  assign range_q = '0;
`endif

  // State register.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and timer load; the timer is loaded with the new phase length on each entry.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_len   = TIMER_W'(CLR_CYCLES);
    case (state)
      IDLE: begin
        if (bus.run || bus.single) begin
          state_next = CLR;
          load       = 1'b1;
        end
      end
      CLR: begin
        if (zero) begin
          state_next = GATE;
          load       = 1'b1;
          load_len   = TIMER_W'(gate_len(GATE_CYCLES, range_q));
        end
      end
      GATE: begin
        if (zero) begin
          state_next = LATCH;
          load       = 1'b1;
          load_len   = TIMER_W'(1);
        end
      end
      LATCH: begin
        load = 1'b1;
        if (retry) begin
          state_next = CLR;
        end else begin
          state_next = HOLD;
          load_len   = TIMER_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        if (zero) begin
          if (bus.run) begin
            state_next = CLR;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore strobes decoded from registered state only, so they are mutually exclusive.
  assign bus.clear     = (state == CLR);
  assign bus.w_enable  = (state == GATE);
  assign bus.save      = (state == LATCH) && !retry;
  assign bus.meas_done = (state == LATCH) && !retry;
  assign bus.busy      = (state != IDLE);
  assign bus.range     = range_q;

endmodule

// File: tb/tb_freq_meter_seq.sv
// Directed bench for freq_meter_seq: cycle-exact strobe schedule against a hand-built timeline.
module tb_freq_meter_seq;

  localparam int C = 2;
  localparam int H = 10;
`ifdef FREQ_SEQ_AUTORANGE_EN
  localparam int G = 1000;
`else
  localparam int G = 100;
`endif

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  freq_meter_seq_if bus();

  freq_meter_seq #(.GATE_CYCLES(G), .CLR_CYCLES(C), .HOLD_CYCLES(H)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  int checks   = 0;
  int failures = 0;
  int cyc_idx  = 0;
  int drop_at  = -1;
  int single_at = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: sample at the falling edge, compare, then apply any scheduled stimulus.
  task automatic step(input string tag, input logic e_clr, input logic e_wen,
                      input logic e_save, input logic e_busy, input logic [1:0] e_rng);
    string t;
    @(negedge c_clk);
    cyc_idx++;
    t = $sformatf("%s@%0d", tag, cyc_idx);
    check({t, ".clear"},     32'(bus.clear),     32'(e_clr));
    check({t, ".w_enable"},  32'(bus.w_enable),  32'(e_wen));
    check({t, ".save"},      32'(bus.save),      32'(e_save));
    check({t, ".meas_done"}, 32'(bus.meas_done), 32'(e_save));
    check({t, ".busy"},      32'(bus.busy),      32'(e_busy));
    check({t, ".range"},     32'(bus.range),     32'(e_rng));
    check({t, ".exclusive"}, 32'(($countones({bus.clear, bus.w_enable, bus.save})) <= 1), 32'd1);
    if (cyc_idx == drop_at) bus.run = 1'b0;
    if (cyc_idx == single_at) bus.single = 1'b1;
    else if (cyc_idx == single_at + 1) bus.single = 1'b0;
  endtask

  // Expected timeline: n_att attempts (retries on overflow), last one saves and holds,
  // then idle_after idle cycles. ovf_mode 1 drops ovf once the first gate has ended.
  task automatic sched(input string tag, input int n_att,
                       input int g0, input int g1, input int g2, input int g3,
                       input int idle_after, input int ovf_mode);
    int gl[4];
    logic [1:0] rng;
    gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
    cyc_idx = 0;
    for (int a = 0; a < n_att; a++) begin
      rng = 2'(a);
      for (int i = 0; i < C; i++) step(tag, 1'b1, 1'b0, 1'b0, 1'b1, rng);
      for (int i = 0; i < gl[a]; i++) step(tag, 1'b0, 1'b1, 1'b0, 1'b1, rng);
      step(tag, 1'b0, 1'b0, (a == n_att - 1), 1'b1, rng);
      if (a == 0 && ovf_mode == 1) bus.ovf = 1'b0;
    end
    rng = 2'(n_att - 1);
    for (int i = 0; i < H; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b1, rng);
    for (int i = 0; i < idle_after; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, rng);
    drop_at   = -1;
    single_at = -1;
  endtask

  // Single is sampled at the edge called edge 0; cycle 1 follows it.
  task automatic start_single();
    @(negedge c_clk);
    bus.single = 1'b1;
    @(posedge c_clk);
    #1 bus.single = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    bus.single = 1'b0;
    bus.ovf = 1'b0;

    // Reset state.
    repeat (3) @(negedge c_clk);
    check("rst.clear",     32'(bus.clear),     32'd0);
    check("rst.w_enable",  32'(bus.w_enable),  32'd0);
    check("rst.save",      32'(bus.save),      32'd0);
    check("rst.meas_done", 32'(bus.meas_done), 32'd0);
    check("rst.busy",      32'(bus.busy),      32'd0);
    check("rst.range",     32'(bus.range),     32'd0);
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    check("idle.busy", 32'(bus.busy), 32'd0);

    // One-shot: clear 1-2, gate 3..G+2, save G+3, busy low from G+C+H+2.
    start_single();
    sched("single", 1, G, 0, 0, 0, 4, 0);

`ifdef FREQ_SEQ_AUTORANGE_EN
    // Overflow in the first gate only: silent retry at range 1 with a 125-cycle gate.
    bus.ovf = 1'b1;
    start_single();
    sched("ar_first", 2, 1000, 125, 0, 0, 3, 1);

    // Overflow on every gate: 1000, 125, 15, 1; the range-3 attempt saves.
    bus.ovf = 1'b1;
    start_single();
    sched("ar_all", 4, 1000, 125, 15, 1, 3, 2);
    bus.ovf = 1'b0;
`else
    // Overflow is ignored without autorange: normal save at range 0.
    bus.ovf = 1'b1;
    start_single();
    sched("ovf_ign", 1, G, 0, 0, 0, 3, 1);
    bus.ovf = 1'b0;
`endif

    // Continuous mode (run and single together): back-to-back measurements spaced
    // C+G+1+H cycles; run drops mid-gate of the third and a busy single pulse is ignored.
    @(negedge c_clk);
    bus.run = 1'b1;
    bus.single = 1'b1;
    @(posedge c_clk);
    #1 bus.single = 1'b0;
    sched("cont1", 1, G, 0, 0, 0, 0, 0);
    sched("cont2", 1, G, 0, 0, 0, 0, 0);
    drop_at   = C + 48;
    single_at = C + 58;
    sched("cont3", 1, G, 0, 0, 0, 6, 0);

    // Reset mid-measurement: with ovf held, autorange is in its range-1 retry by now.
    bus.ovf = 1'b1;
    start_single();
    repeat (C + G + 1 + 5) @(negedge c_clk);
    check("midrst.pre_busy", 32'(bus.busy), 32'd1);
`ifdef FREQ_SEQ_AUTORANGE_EN
    check("midrst.pre_range", 32'(bus.range), 32'd1);
`else
    check("midrst.pre_range", 32'(bus.range), 32'd0);
`endif
    reset = 1'b1;
    #1;
    check("midrst.clear",     32'(bus.clear),     32'd0);
    check("midrst.w_enable",  32'(bus.w_enable),  32'd0);
    check("midrst.save",      32'(bus.save),      32'd0);
    check("midrst.meas_done", 32'(bus.meas_done), 32'd0);
    check("midrst.busy",      32'(bus.busy),      32'd0);
    check("midrst.range",     32'(bus.range),     32'd0);
    bus.ovf = 1'b0;
    @(negedge c_clk);
    reset = 1'b0;
    repeat (3) @(negedge c_clk);
    check("midrst.post_busy", 32'(bus.busy), 32'd0);
    check("midrst.post_save", 32'(bus.save), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
